sprite_anim_ctrl: RTL and testbench
===================================

Name: sprite_anim_ctrl

Overview:
- Sequences the 4-direction sprite ROM: per pixel, computes the ROM address for the current direction and animation frame of one on-screen sprite at (PosX, PosY).
- Flags whether the current pixel lies inside the sprite.
- Latches direction and walk state only on frame boundaries, so a sprite never tears mid-frame.
- Sits between the VGA controller (DrawX/DrawY/blank), the game logic (position, direction, moving), and the negedge-clocked sprite ROM plus palette.

Parameters:
- SPR_W, 28: sprite width in pixels.
- SPR_H, 38: sprite height in pixels.
- FRAMES, 2: walk frames per direction (>=1).
- ANIM_DIV, 8: frame_ticks per walk-frame advance (>=1).
- ADDR_W, 14: ROM address width; must cover 4*FRAMES*SPR_W*SPR_H words.

Ports:
- vga_clk  in  1  pixel clock; all state updates on posedge.
- Reset  in  1  synchronous, active-high reset.
- DrawX  in  10  current pixel column.
- DrawY  in  10  current pixel row.
- blank  in  1  1 = visible region (pixel may be drawn).
- frame_tick  in  1  one-cycle pulse once per video frame (vsync region).
- PosX  in  10  sprite top-left column.
- PosY  in  10  sprite top-left row.
- dir_req  in  2  requested direction: 0 down, 1 right, 2 up, 3 left.
- moving  in  1  1 = character walking.
- rom_address  out  ADDR_W  address to sprite ROM.
- sprite_on  out  1  current pixel belongs to the sprite.
- cur_dir  out  2  latched direction.
- cur_frame  out  $clog2(FRAMES) (min 1)  latched walk frame.

Behaviour:
- Reset, which wins over every other input in the same cycle:
  - rom_address=0, sprite_on=0, cur_dir=0, cur_frame=0.
  - Divider counter=0, FSM=STAND.
- FSM states: STAND, WALK. Transitions are evaluated only in cycles with frame_tick=1.
- On every frame_tick:
  - cur_dir <= dir_req, whatever the state.
  - STAND, moving=1: go to WALK; divider=0; cur_frame stays 0.
  - WALK, moving=0: go to STAND; cur_frame<=0; divider<=0.
  - WALK, moving=1: divider increments. When divider==ANIM_DIV-1, it wraps to 0 and cur_frame advances. cur_frame wraps FRAMES-1 -> 0.
- STAND always shows frame 0.
- dir_req and moving changes between ticks are ignored.
- A dir_req change in the same cycle as frame_tick takes effect in that tick.
- Hit test:
  - Zero-extend all coordinates to 11 bits.
  - col = DrawX-PosX, row = DrawY-PosY.
  - hit = DrawX>=PosX and DrawX<PosX+SPR_W and DrawY>=PosY and DrawY<PosY+SPR_H.
  - A sprite clipped at the right/bottom edge (PosX up to 639) must not wrap.
- Address: ((cur_dir*FRAMES + cur_frame)*SPR_H + row)*SPR_W + col, truncated to ADDR_W.
- When hit=0, the address is don't-care; drive 0.
- Latency: rom_address and sprite_on are registered together on the posedge after DrawX/DrawY are presented (1 cycle).
  - The ROM samples the address on the following negedge.
  - Downstream registers the palette output on the next posedge.
- sprite_on = registered (hit & blank). It is 0 when blank=0 even if hit.
- The address uses the cur_dir/cur_frame values before any update in the same cycle. A tick therefore changes pixels from the next cycle on.

Optional Feature:
- Macro: SPRITE_ANIM_MIRROR_EN.
- Defined:
  - dir 3 (left) reuses the dir-1 (right) strip with col replaced by SPR_W-1-col.
  - The ROM holds only directions 0..2, so the address formula uses 3 strips.
  - cur_dir still reports 3.
- Undefined: all 4 strips are stored and no mirroring occurs.

Test Plan:
1. Reset: assert Reset for 2 cycles mid-line with moving=1 and frame_tick=1 -> all outputs 0, FSM STAND, cur_dir 0 after release.
2. Hit/address: PosX=100, PosY=50, dir_req=2 latched, STAND, DrawX=105, DrawY=60, blank=1 -> one cycle later sprite_on=1, rom_address=(2*2*38+10)*28+5=4541. Same pixel with blank=0 -> sprite_on=0.
3. Edge clip: PosX=630, DrawX=639 -> sprite_on=1, col=9. Also PosX=630, DrawX=5 -> sprite_on=0 (no wrap).
4. Animation: moving=1, ANIM_DIV=8 -> cur_frame goes 0 after tick 1 (enter WALK), 1 after tick 9, 0 after tick 17. moving=0 at the next tick -> STAND, cur_frame=0.
5. Direction timing: toggle dir_req 0->1->3 between ticks -> cur_dir unchanged. dir_req=3 at a tick -> cur_dir=3 next cycle, and addresses switch on the following pixel.
6. Mirror (SPRITE_ANIM_MIRROR_EN): dir 3, frame 0, row 0, col 0 -> rom_address = (1*2*38+0)*28+27 = 2155. Without the macro -> (3*2*38)*28 = 6384.

Source files
------------

// File: rtl/sprite_anim_ctrl.sv
// Sprite ROM sequencer: per-pixel hit test and ROM address for one 4-direction walking sprite.
// Optional build macro SPRITE_ANIM_MIRROR_EN: left-facing frames mirror the right-facing strip.
module sprite_anim_ctrl #(
  parameter int SPR_W    = 28,
  parameter int SPR_H    = 38,
  parameter int FRAMES   = 2,
  parameter int ANIM_DIV = 8,
  parameter int ADDR_W   = 14,
  localparam int FRAME_W = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
  input  logic               vga_clk,
  input  logic               Reset,
  input  logic [9:0]         DrawX,
  input  logic [9:0]         DrawY,
  input  logic               blank,
  input  logic               frame_tick,
  input  logic [9:0]         PosX,
  input  logic [9:0]         PosY,
  input  logic [1:0]         dir_req,
  input  logic               moving,
  output logic [ADDR_W-1:0]  rom_address,
  output logic               sprite_on,
  output logic [1:0]         cur_dir,
  output logic [FRAME_W-1:0] cur_frame
);

  localparam int DIV_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  localparam logic [31:0]        FRAMES32  = 32'(FRAMES);
  localparam logic [31:0]        SPR_W32   = 32'(SPR_W);
  localparam logic [31:0]        SPR_H32   = 32'(SPR_H);
  localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(ANIM_DIV - 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAMES - 1);

  typedef enum logic {STAND, WALK} state_t;

  state_t             state, state_n;
  logic [DIV_W-1:0]   div_cnt, div_cnt_n;
  logic [FRAME_W-1:0] frame_n;
  logic [1:0]         dir_n;

  // Animation FSM: everything advances only on frame_tick so a frame never tears.
  always_comb begin
    state_n   = state;
    div_cnt_n = div_cnt;
    frame_n   = cur_frame;
    dir_n     = cur_dir;
    if (frame_tick) begin
      dir_n = dir_req;
      case (state)
        STAND: begin
          if (moving) begin
            state_n   = WALK;
            div_cnt_n = '0;
            frame_n   = '0;
          end
        end
        WALK: begin
          if (!moving) begin
            state_n   = STAND;
            div_cnt_n = '0;
            frame_n   = '0;
          end else if (div_cnt == DIV_LAST) begin
            div_cnt_n = '0;
            frame_n   = (cur_frame == FRAME_LAST) ? '0 : cur_frame + FRAME_W'(1);
          end else begin
            div_cnt_n = div_cnt + DIV_W'(1);
          end
        end
        default: state_n = STAND;
      endcase
    end
  end

  // Hit test in 11 bits so a sprite near column 639 clips instead of wrapping.
  logic [10:0] draw_x11, draw_y11, pos_x11, pos_y11, x_end, y_end;
  logic [10:0] col, row, col_eff;
  logic [1:0]  strip;
  logic        hit;
  logic [31:0] addr_full;

  always_comb begin
    draw_x11 = {1'b0, DrawX};
    draw_y11 = {1'b0, DrawY};
    pos_x11  = {1'b0, PosX};
    pos_y11  = {1'b0, PosY};
    x_end    = pos_x11 + 11'(SPR_W);
    y_end    = pos_y11 + 11'(SPR_H);
    hit      = (draw_x11 >= pos_x11) && (draw_x11 < x_end) &&
               (draw_y11 >= pos_y11) && (draw_y11 < y_end);
    col      = draw_x11 - pos_x11;
    row      = draw_y11 - pos_y11;
`ifdef SPRITE_ANIM_MIRROR_EN
    if (cur_dir == 2'd3) begin
      strip   = 2'd1;
      col_eff = 11'(SPR_W - 1) - col;
    end else begin
      strip   = cur_dir;
      col_eff = col;
    end
`else
    strip   = cur_dir;
    col_eff = col;
`endif
    addr_full = (((32'(strip) * FRAMES32 + 32'(cur_frame)) * SPR_H32 + 32'(row)) * SPR_W32)
                + 32'(col_eff);
  end

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      state       <= STAND;
      div_cnt     <= '0;
      cur_frame   <= '0;
      cur_dir     <= '0;
      rom_address <= '0;
      sprite_on   <= 1'b0;
    end else begin
      state       <= state_n;
      div_cnt     <= div_cnt_n;
      cur_frame   <= frame_n;
      cur_dir     <= dir_n;
      rom_address <= hit ? addr_full[ADDR_W-1:0] : '0;
      sprite_on   <= hit & blank;
    end
  end

endmodule

// File: tb/tb_sprite_anim_ctrl.sv
// Directed bench for sprite_anim_ctrl with default parameters; honours SPRITE_ANIM_MIRROR_EN.
module tb_sprite_anim_ctrl;

  logic        vga_clk = 1'b0;
  logic        Reset;
  logic [9:0]  DrawX, DrawY, PosX, PosY;
  logic        blank, frame_tick, moving;
  logic [1:0]  dir_req;
  logic [13:0] rom_address;
  logic        sprite_on;
  logic [1:0]  cur_dir;
  logic [0:0]  cur_frame;

  int checks   = 0;
  int failures = 0;

  sprite_anim_ctrl #(.SPR_W(28), .SPR_H(38), .FRAMES(2), .ANIM_DIV(8), .ADDR_W(14)) dut (
    .vga_clk    (vga_clk),
    .Reset      (Reset),
    .DrawX      (DrawX),
    .DrawY      (DrawY),
    .blank      (blank),
    .frame_tick (frame_tick),
    .PosX       (PosX),
    .PosY       (PosY),
    .dir_req    (dir_req),
    .moving     (moving),
    .rom_address(rom_address),
    .sprite_on  (sprite_on),
    .cur_dir    (cur_dir),
    .cur_frame  (cur_frame)
  );

  always #5 vga_clk = ~vga_clk;

  task automatic step();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic [1:0] d, input logic mv);
    dir_req    = d;
    moving     = mv;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  initial begin
    // Reset held two cycles with competing inputs active
    Reset = 1'b1; moving = 1'b1; frame_tick = 1'b1; dir_req = 2'd2;
    PosX = 10'd100; PosY = 10'd50; DrawX = 10'd105; DrawY = 10'd60; blank = 1'b1;
    step();
    step();
    chk("rst_addr",  32'(rom_address), 32'd0);
    chk("rst_on",    32'(sprite_on),   32'd0);
    chk("rst_dir",   32'(cur_dir),     32'd0);
    chk("rst_frame", 32'(cur_frame),   32'd0);
    Reset = 1'b0; frame_tick = 1'b0; moving = 1'b0; blank = 1'b0;
    step();
    chk("post_rst_dir",   32'(cur_dir),   32'd0);
    chk("post_rst_frame", 32'(cur_frame), 32'd0);

    // Latch direction 2 while standing, then hit test
    tick(2'd2, 1'b0);
    chk("dir_latch2", 32'(cur_dir), 32'd2);
    blank = 1'b1;
    step();
    chk("hit_on",   32'(sprite_on),   32'd1);
    chk("hit_addr", 32'(rom_address), 32'd4541);
    blank = 1'b0;
    step();
    chk("blank_off", 32'(sprite_on), 32'd0);
    blank = 1'b1;

    // Right/bottom boundaries
    DrawX = 10'd127;
    step();
    chk("last_col_on",   32'(sprite_on),   32'd1);
    chk("last_col_addr", 32'(rom_address), 32'd4563);
    DrawX = 10'd128;
    step();
    chk("past_col_on",   32'(sprite_on),   32'd0);
    chk("past_col_addr", 32'(rom_address), 32'd0);
    DrawX = 10'd105; DrawY = 10'd88;
    step();
    chk("past_row_on", 32'(sprite_on), 32'd0);
    DrawX = 10'd99; DrawY = 10'd60;
    step();
    chk("left_of_on", 32'(sprite_on), 32'd0);

    // Clip at the right screen edge without wrap
    PosX = 10'd630; DrawX = 10'd639;
    step();
    chk("clip_on",   32'(sprite_on),   32'd1);
    chk("clip_addr", 32'(rom_address), 32'd4545);
    DrawX = 10'd5;
    step();
    chk("nowrap_on",   32'(sprite_on),   32'd0);
    chk("nowrap_addr", 32'(rom_address), 32'd0);

    // Animation: tick 1 enters WALK, frame advances on ticks 9, 17, 25
    PosX = 10'd100; DrawX = 10'd105; DrawY = 10'd60;
    tick(2'd2, 1'b1);
    chk("walk_t1", 32'(cur_frame), 32'd0);
    for (int i = 2; i <= 8; i++) tick(2'd2, 1'b1);
    chk("walk_t8", 32'(cur_frame), 32'd0);
    // moving drops between ticks: must be ignored
    moving = 1'b0;
    step();
    step();
    chk("walk_ignore_mv", 32'(cur_frame), 32'd0);
    tick(2'd2, 1'b1);
    chk("walk_t9", 32'(cur_frame), 32'd1);
    for (int i = 10; i <= 16; i++) tick(2'd2, 1'b1);
    chk("walk_t16", 32'(cur_frame), 32'd1);
    tick(2'd2, 1'b1);
    chk("walk_t17", 32'(cur_frame), 32'd0);
    for (int i = 18; i <= 25; i++) tick(2'd2, 1'b1);
    chk("walk_t25", 32'(cur_frame), 32'd1);
    step();
    chk("frame1_addr", 32'(rom_address), 32'd5605);
    tick(2'd2, 1'b0);
    chk("stop_frame", 32'(cur_frame), 32'd0);
    // Re-entering WALK restarts the divider
    tick(2'd2, 1'b1);
    for (int i = 2; i <= 8; i++) tick(2'd2, 1'b1);
    chk("rewalk_t8", 32'(cur_frame), 32'd0);
    tick(2'd2, 1'b1);
    chk("rewalk_t9", 32'(cur_frame), 32'd1);
    tick(2'd2, 1'b0);
    chk("stand_again", 32'(cur_frame), 32'd0);

    // Direction changes between ticks are ignored
    dir_req = 2'd0; step();
    chk("dir_hold0", 32'(cur_dir), 32'd2);
    dir_req = 2'd1; step();
    chk("dir_hold1", 32'(cur_dir), 32'd2);
    dir_req = 2'd3; step();
    chk("dir_hold3", 32'(cur_dir), 32'd2);

    // dir 3 at a tick: the pixel in that cycle still uses dir 2
    DrawX = 10'd100; DrawY = 10'd50;
    tick(2'd3, 1'b0);
    chk("dir3_latched", 32'(cur_dir),     32'd3);
    chk("dir3_old_addr", 32'(rom_address), 32'd4256);
    step();
`ifdef SPRITE_ANIM_MIRROR_EN
    chk("dir3_new_addr", 32'(rom_address), 32'd2155);
`else
    chk("dir3_new_addr", 32'(rom_address), 32'd6384);
`endif
    chk("dir3_on", 32'(sprite_on), 32'd1);

    // Reset wins over a simultaneous tick
    Reset = 1'b1; frame_tick = 1'b1; moving = 1'b1; dir_req = 2'd1;
    step();
    chk("rst2_dir",  32'(cur_dir),     32'd0);
    chk("rst2_addr", 32'(rom_address), 32'd0);
    chk("rst2_on",   32'(sprite_on),   32'd0);
    Reset = 1'b0; frame_tick = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
